// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Microcoded control unit for a simple 8-bit bus machine. Each instruction is
// a fixed two-step fetch (T0, T1) followed by up to three execute steps
// (T2..T4) selected by the opcode nibble and the latched carry/zero flags.
// The control word is decoded combinationally from the current step, opcode,
// flags, halted state and reset; only the step counter and the halted flag
// are registered.
//
// Parameters:
//   EARLY_END  1: an instruction ends as soon as its next microstep is empty
//              0: every instruction runs all five steps
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   opcode   instruction upper nibble (not latched here)
//   cf, zf   latched carry / zero flags
//   hlt..fi  control lines; ro, io, ao, eo and co drive the bus
//   step     current microstep (0..4)
//   halted   processor stopped; cleared only by rst
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi,
    output logic [2:0] step,
    output logic       halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Control word layout, MSB first: hlt mi ri ro io ii ai ao eo su bi oi ce co j fi
    localparam logic [15:0] CW_HLT = 16'h8000;
    localparam logic [15:0] CW_MI  = 16'h4000;
    localparam logic [15:0] CW_RI  = 16'h2000;
    localparam logic [15:0] CW_RO  = 16'h1000;
    localparam logic [15:0] CW_IO  = 16'h0800;
    localparam logic [15:0] CW_II  = 16'h0400;
    localparam logic [15:0] CW_AI  = 16'h0200;
    localparam logic [15:0] CW_AO  = 16'h0100;
    localparam logic [15:0] CW_EO  = 16'h0080;
    localparam logic [15:0] CW_SU  = 16'h0040;
    localparam logic [15:0] CW_BI  = 16'h0020;
    localparam logic [15:0] CW_OI  = 16'h0010;
    localparam logic [15:0] CW_CE  = 16'h0008;
    localparam logic [15:0] CW_CO  = 16'h0004;
    localparam logic [15:0] CW_J   = 16'h0002;
    localparam logic [15:0] CW_FI  = 16'h0001;
    localparam int          HLT_BIT = 15;

    step_t       step_r;
    logic        halted_r;
    step_t       step_nxt_s;
    logic [15:0] word_s;
    logic [15:0] ctrl_s;
    logic [15:0] next_word_s;
    logic [2:0]  step_inc_s;

    // Microcode ROM. Each word drives at most one of ro/io/ao/eo/co, so the
    // bus can never be contended. Step values above T4 decode to empty so the
    // look-ahead from T4 is harmless.
    function automatic logic [15:0] micro_word(
        input logic [3:0] op,
        input logic [2:0] st,
        input logic       c,
        input logic       z
    );
        logic [15:0] w;
        w = 16'h0000;
        case (st)
            3'd0: w = CW_CO | CW_MI;
            3'd1: w = CW_RO | CW_II | CW_CE;
            3'd2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: w = CW_IO | CW_MI;
                    4'h5:    w = CW_IO | CW_AI;
                    4'h6:    w = CW_IO | CW_J;
                    4'h7:    w = c ? (CW_IO | CW_J) : 16'h0000;
                    4'h8:    w = z ? (CW_IO | CW_J) : 16'h0000;
                    4'hE:    w = CW_AO | CW_OI;
                    4'hF:    w = CW_HLT;
                    default: w = 16'h0000;
                endcase
            end
            3'd3: begin
                case (op)
                    4'h1:       w = CW_RO | CW_AI;
                    4'h2, 4'h3: w = CW_RO | CW_BI;
                    4'h4:       w = CW_AO | CW_RI;
                    default:    w = 16'h0000;
                endcase
            end
            3'd4: begin
                case (op)
                    4'h2:    w = CW_EO | CW_AI | CW_FI;
                    4'h3:    w = CW_EO | CW_AI | CW_SU | CW_FI;
                    default: w = 16'h0000;
                endcase
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Decode the live control word; reset blanks everything, halt leaves only hlt.
    always_comb begin
        word_s = micro_word(opcode, step_r, cf, zf);
        if (rst) begin
            ctrl_s = 16'h0000;
        end else if (halted_r) begin
            ctrl_s = CW_HLT;
        end else begin
            ctrl_s = word_s;
        end
    end

    // Next-step selection; the early-end look-ahead uses the current opcode and flags.
    always_comb begin
        step_inc_s  = step_r + 3'd1;
        next_word_s = micro_word(opcode, step_inc_s, cf, zf);
        if (step_r == T4) begin
            step_nxt_s = T0;
        end else if ((EARLY_END == 1'b1) && (step_r != T0) && (next_word_s == 16'h0000)) begin
            step_nxt_s = T0;
        end else begin
            step_nxt_s = step_t'(step_inc_s);
        end
    end

    // Step/halt state; reset wins over halt, and a halt freezes the step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r   <= T0;
            halted_r <= 1'b0;
        end else if (ctrl_s[HLT_BIT]) begin
            halted_r <= 1'b1;
        end else begin
            step_r   <= step_nxt_s;
        end
    end

    assign {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi} = ctrl_s;
    assign step   = step_r;
    assign halted = halted_r;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Drives two sequencers (EARLY_END=1 and EARLY_END=0) from shared inputs and
// checks them against a reference model built from per-opcode microcode
// tables and instruction lengths, plus a table of per-opcode step sequences
// and directed halt / mid-instruction reset sequences.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       cf;
    logic       zf;

    wire [15:0] cw0;
    wire [15:0] cw1;
    wire [2:0]  st0;
    wire [2:0]  st1;
    wire        hd0;
    wire        hd1;

    always #5 clk = ~clk;

    control_sequencer #(.EARLY_END(1'b1)) dut_ee1 (
        .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
        .hlt(cw1[15]), .mi(cw1[14]), .ri(cw1[13]), .ro(cw1[12]),
        .io(cw1[11]), .ii(cw1[10]), .ai(cw1[9]), .ao(cw1[8]),
        .eo(cw1[7]), .su(cw1[6]), .bi(cw1[5]), .oi(cw1[4]),
        .ce(cw1[3]), .co(cw1[2]), .j(cw1[1]), .fi(cw1[0]),
        .step(st1), .halted(hd1)
    );

    control_sequencer #(.EARLY_END(1'b0)) dut_ee0 (
        .clk(clk), .rst(rst), .opcode(opcode), .cf(cf), .zf(zf),
        .hlt(cw0[15]), .mi(cw0[14]), .ri(cw0[13]), .ro(cw0[12]),
        .io(cw0[11]), .ii(cw0[10]), .ai(cw0[9]), .ao(cw0[8]),
        .eo(cw0[7]), .su(cw0[6]), .bi(cw0[5]), .oi(cw0[4]),
        .ce(cw0[3]), .co(cw0[2]), .j(cw0[1]), .fi(cw0[0]),
        .step(st0), .halted(hd0)
    );

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    typedef struct {
        logic [3:0]  op;
        logic        cf;
        logic        zf;
        logic [15:0] t2;
        logic [15:0] t3;
        logic [15:0] t4;
        int          len;   // steps per instruction with EARLY_END=1
    } vec_t;

    vec_t        vt [18];
    logic [15:0] mc [16][3];
    int          ms [2];
    bit          mh [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_word(input logic [3:0] op, input int st,
                                           input logic c, input logic z);
        if (st == 0) return C_CO | C_MI;
        if (st == 1) return C_RO | C_II | C_CE;
        if (st > 4) return 16'h0000;
        if ((op == 4'd7 && !c) || (op == 4'd8 && !z)) return 16'h0000;
        return mc[op][st-2];
    endfunction

    function automatic int m_len(input logic [3:0] op, input logic c, input logic z);
        int n = 2;
        for (int s = 2; s <= 4; s++) begin
            if (m_word(op, s, c, z) != 16'h0000) n = s + 1;
        end
        return n;
    endfunction

    function automatic logic [15:0] m_exp(input int e);
        if (rst) return 16'h0000;
        if (mh[e]) return C_HLT;
        return m_word(opcode, ms[e], cf, zf);
    endfunction

    function automatic int busc(input logic [15:0] w);
        return int'(w[12]) + int'(w[11]) + int'(w[8]) + int'(w[7]) + int'(w[2]);
    endfunction

    task automatic model_update();
        logic [15:0] w;
        for (int e = 0; e < 2; e++) begin
            w = m_exp(e);
            if (rst) begin
                ms[e] = 0;
                mh[e] = 1'b0;
            end else if (w[15]) begin
                mh[e] = 1'b1;
            end else if (e == 1) begin
                ms[e] = (ms[e] + 1 >= m_len(opcode, cf, zf)) ? 0 : ms[e] + 1;
            end else begin
                ms[e] = (ms[e] == 4) ? 0 : ms[e] + 1;
            end
        end
    endtask

    task automatic model_compare();
        ck("ee0_word",   cw0, m_exp(0));
        ck("ee0_step",   st0, ms[0]);
        ck("ee0_halted", hd0, mh[0]);
        ck("ee0_bus",    busc(cw0) <= 1, 1);
        ck("ee1_word",   cw1, m_exp(1));
        ck("ee1_step",   st1, ms[1]);
        ck("ee1_halted", hd1, mh[1]);
        ck("ee1_bus",    busc(cw1) <= 1, 1);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
        model_compare();
    endtask

    task automatic apply(input logic r, input logic [3:0] op, input logic c, input logic z);
        rst = r; opcode = op; cf = c; zf = z;
        #1;
        model_compare();
    endtask

    task automatic do_reset(input logic [3:0] op);
        apply(1'b1, op, cf, zf);
        tick();
        apply(1'b0, op, cf, zf);
    endtask

    function automatic logic [15:0] tw(input vec_t v, input int s);
        case (s)
            0:       return C_CO | C_MI;
            1:       return C_RO | C_II | C_CE;
            2:       return v.t2;
            3:       return v.t3;
            4:       return v.t4;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        vt[0]  = '{4'h0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[1]  = '{4'h1, 1'b1, 1'b1, C_IO | C_MI, C_RO | C_AI, 16'h0000, 4};
        vt[2]  = '{4'h2, 1'b1, 1'b1, C_IO | C_MI, C_RO | C_BI, C_EO | C_AI | C_FI, 5};
        vt[3]  = '{4'h3, 1'b1, 1'b1, C_IO | C_MI, C_RO | C_BI, C_EO | C_AI | C_SU | C_FI, 5};
        vt[4]  = '{4'h4, 1'b1, 1'b1, C_IO | C_MI, C_AO | C_RI, 16'h0000, 4};
        vt[5]  = '{4'h5, 1'b1, 1'b1, C_IO | C_AI, 16'h0000, 16'h0000, 3};
        vt[6]  = '{4'h6, 1'b1, 1'b1, C_IO | C_J, 16'h0000, 16'h0000, 3};
        vt[7]  = '{4'h7, 1'b1, 1'b1, C_IO | C_J, 16'h0000, 16'h0000, 3};
        vt[8]  = '{4'h8, 1'b1, 1'b1, C_IO | C_J, 16'h0000, 16'h0000, 3};
        vt[9]  = '{4'h9, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[10] = '{4'hA, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[11] = '{4'hB, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[12] = '{4'hC, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[13] = '{4'hD, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[14] = '{4'hE, 1'b1, 1'b1, C_AO | C_OI, 16'h0000, 16'h0000, 3};
        vt[15] = '{4'hF, 1'b1, 1'b1, C_HLT, 16'h0000, 16'h0000, 3};
        vt[16] = '{4'h7, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2};
        vt[17] = '{4'h8, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2};
        for (int o = 0; o < 16; o++) begin
            mc[o][0] = vt[o].t2;
            mc[o][1] = vt[o].t3;
            mc[o][2] = vt[o].t4;
        end
        ms[0] = 0; ms[1] = 0; mh[0] = 1'b0; mh[1] = 1'b0;

        // Initial reset edge
        rst = 1'b1; opcode = 4'h0; cf = 1'b0; zf = 1'b0;
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
        model_compare();
        ck("reset_all_zero", cw1 | cw0, 16'h0000);
        ck("reset_step", st1, 0);
        apply(1'b0, 4'h0, 1'b0, 1'b0);
        ck("post_reset_word", cw1, C_CO | C_MI);

        // Table: per-opcode step sequences and words for both variants
        for (int i = 0; i < 18; i++) begin
            int kmax;
            do_reset(vt[i].op);
            apply(1'b0, vt[i].op, vt[i].cf, vt[i].zf);
            kmax = (vt[i].op == 4'hF) ? 2 : 5;
            for (int k = 0; k <= kmax; k++) begin
                ck($sformatf("tbl%0d_ee1_step_k%0d", i, k), st1, k % vt[i].len);
                ck($sformatf("tbl%0d_ee1_word_k%0d", i, k), cw1, tw(vt[i], k % vt[i].len));
                ck($sformatf("tbl%0d_ee0_step_k%0d", i, k), st0, k % 5);
                ck($sformatf("tbl%0d_ee0_word_k%0d", i, k), cw0, tw(vt[i], k % 5));
                if (k < kmax) tick();
            end
        end

        // Sweep of every opcode and flag combination (bus exclusivity via model_compare)
        for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                do_reset(4'(op));
                apply(1'b0, 4'(op), fl[0], fl[1]);
                repeat (5) tick();
                ck("sweep_no_j_when_not_taken",
                   ((op == 7 && fl[0] == 1'b0) || (op == 8 && fl[1] == 1'b0)) ? 32'(cw1[1]) : 32'd0, 0);
            end
        end

        // HLT at T2: halts from the next cycle, step frozen, only hlt, cleared by rst
        do_reset(4'hF);
        apply(1'b0, 4'hF, 1'b0, 1'b0);
        tick(); tick();
        ck("hlt_t2_word", cw1, C_HLT);
        ck("hlt_t2_not_halted_yet", hd1, 0);
        tick();
        ck("hlt_halted", hd1, 1);
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, 4'(c), c[0], c[1]);
            ck("hlt_freeze_step", st1, 2);
            ck("hlt_only_hlt", cw1, C_HLT);
            ck("hlt_ee0_only_hlt", cw0, C_HLT);
            tick();
        end
        apply(1'b1, 4'hF, 1'b0, 1'b0);
        ck("hlt_rst_word", cw1, 16'h0000);
        tick();
        ck("hlt_rst_step", st1, 0);
        ck("hlt_rst_halted", hd1, 0);
        apply(1'b0, 4'h0, 1'b0, 1'b0);
        ck("hlt_release_word", cw1, C_CO | C_MI);

        // Reset in T3 of STA abandons the store
        do_reset(4'h4);
        apply(1'b0, 4'h4, 1'b0, 1'b0);
        tick(); tick(); tick();
        ck("sta_t3_word", cw1, C_AO | C_RI);
        apply(1'b1, 4'h4, 1'b0, 1'b0);
        ck("sta_rst_ao", cw1[8], 0);
        ck("sta_rst_ri", cw1[13], 0);
        tick();
        ck("sta_rst_step", st1, 0);
        apply(1'b0, 4'h4, 1'b0, 1'b0);
        ck("sta_release_word", cw1, C_CO | C_MI);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            apply($urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
